// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types for the UART transmit arbiter.
// FSM state encoding and round-robin helper.
package uart_tx_arbiter_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_ISSUE     = 3'd2,
        S_WAIT_BUSY = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_LOCK_WAIT = 3'd5,
        S_GAP       = 3'd6
    } arb_state_t;

    function automatic int unsigned rr_next(
        input int unsigned idx,
        input int unsigned n
    );
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Round-robin picker: first set bit of i_cand at or after i_ptr.
// Ports: i_cand, i_ptr in; o_idx, o_found out.
module uart_tx_arbiter_rr_picker #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  i_cand,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_found
);

    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;

    // Rotate so bit 0 of w_rot is the requester at i_ptr.
    assign w_dbl = {i_cand, i_cand};
    assign w_rot = NREQ'(w_dbl >> i_ptr);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        // Walk downwards so the lowest offset wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_idx   = IDX_W'((int'(i_ptr) + k) % NREQ);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one 8N1 transmitter among NREQ requesters, round-robin with packet lock.
// Ports: req_* client side, tx_* transmitter side, grant_id/busy status.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int GAP_BITS = 2,
    parameter int LOCK_TO  = 16,
    parameter int IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_en,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [8*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic              tx_en,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic [IDX_W-1:0]  grant_id,
    output logic              busy
);

    localparam int LT_W     = $clog2(LOCK_TO) + 1;
    localparam int GW       = $clog2(GAP_BITS + 1) + 1;
    localparam int GAP_LAST = (GAP_BITS > 0) ? GAP_BITS - 1 : 0;

    arb_state_t       r_state;
    arb_state_t       w_state_nx;
    logic [IDX_W-1:0] r_grant;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_pick;
    logic             w_found;
    logic [7:0]       r_tx_data;
    logic             r_last;
    logic             r_tx_en;
    logic [LT_W-1:0]  r_lock_cnt;
    logic [GW-1:0]    r_gap_cnt;
    logic [NREQ-1:0]  w_cand;
    logic [NREQ-1:0]  w_ready;
    logic             w_tx_rdy;
    logic             w_gv;
    logic             w_ge;
    logic             w_gap_end;
    logic             w_lock_end;

    // An unknown ready during transmitter power-up counts as busy.
    assign w_tx_rdy   = (tx_ready === 1'b1);
    assign w_cand     = req_valid & req_en;
    assign w_gv       = req_valid[r_grant];
    assign w_ge       = req_en[r_grant];
    assign w_gap_end  = (r_gap_cnt == GW'(GAP_LAST));
    assign w_lock_end = (r_lock_cnt == LT_W'(LOCK_TO - 1));

    uart_tx_arbiter_rr_picker #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_cand  (w_cand),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick),
        .o_found (w_found)
    );

    always_comb begin
        w_state_nx = r_state;
        w_ready    = '0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found && w_tx_rdy) w_state_nx = S_LOAD;
            end
            S_LOAD: begin
                w_ready[r_grant] = 1'b1;
                if (w_gv) w_state_nx = S_ISSUE;
            end
            S_ISSUE: begin
                w_state_nx = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (!w_tx_rdy) w_state_nx = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (w_tx_rdy) begin
                    if (r_last || !w_ge) w_state_nx = S_GAP;
                    else if (w_gv)       w_state_nx = S_LOAD;
                    else                 w_state_nx = S_LOCK_WAIT;
                end
            end
            S_LOCK_WAIT: begin
                if (w_gv && w_ge)            w_state_nx = S_LOAD;
                else if (!w_ge || w_lock_end) w_state_nx = S_GAP;
            end
            S_GAP: begin
                if (w_gap_end) w_state_nx = S_IDLE;
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tx_en    <= 1'b0;
            r_tx_data  <= '0;
            r_last     <= 1'b0;
            r_grant    <= '0;
            r_rr_ptr   <= '0;
            r_lock_cnt <= '0;
            r_gap_cnt  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_tx_en <= 1'b1;
            if (r_state == S_IDLE && w_state_nx == S_LOAD) begin
                r_grant <= w_pick;
            end
            if (r_state == S_LOAD && w_gv) begin
                r_tx_data <= req_data[{r_grant, 3'b000} +: 8];
                r_last    <= req_last[r_grant];
            end
            // Lock timer runs only while waiting inside a packet.
            if (r_state == S_LOCK_WAIT) r_lock_cnt <= r_lock_cnt + 1'b1;
            else                        r_lock_cnt <= '0;
            if (r_state == S_GAP) r_gap_cnt <= r_gap_cnt + 1'b1;
            else                  r_gap_cnt <= '0;
            // Packet end: the requester after the winner gets top priority.
            if (r_state != S_GAP && w_state_nx == S_GAP) begin
                r_rr_ptr <= IDX_W'(rr_next(int'(r_grant), NREQ));
            end
        end
    end

    assign req_ready = w_ready;
    assign tx_en     = r_tx_en;
    assign tx_valid  = (r_state == S_ISSUE);
    assign tx_data   = r_tx_data;
    assign grant_id  = r_grant;
    assign busy      = (r_state != S_IDLE);

endmodule
